// File: rtl/cpu_bus_pkg.sv
// Shared types and default sizing for the CPU memory-bus front end.
package cpu_bus_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_bus_wait_timer.sv
// Saturating wait-state counter; expired_o flags the last permitted wait cycle.
module cpu_bus_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wait_cnt_q;

  // Count low-RDY cycles; hold at TIMEOUT instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wait_cnt_q <= '0;
    end else if (en_i && (wait_cnt_q != CntW'(TIMEOUT))) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign expired_o = (wait_cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_bus_master.sv
// Request/response front end driving a wait-state-aware external memory bus.
// Optional bus timeout enabled by defining CPU_BUS_TIMEOUT_EN; without it BUS
// waits indefinitely for RDY and rsp_err stays 0.
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOE,
  output logic              W,
  input  logic [DATA_W-1:0] DIN,
  input  logic              RDY
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("cpu_bus_master: TIMEOUT must be at least 1");
  end

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              timer_expired;
  logic              bus_act;

`ifdef CPU_BUS_TIMEOUT_EN
  cpu_bus_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     ((state_q == StIdle) && req_valid),
    .en_i      ((state_q == StBus) && !RDY),
    .expired_o (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  // Transfer sequencing: capture request, wait for RDY (or expiry), hold response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
            state_q <= StBus;
          end
        end
        StBus: begin
          // RDY takes priority over an expiry in the same cycle.
          if (RDY) begin
            rdata_q <= write_q ? '0 : DIN;
            err_q   <= 1'b0;
            state_q <= StResp;
          end else if (timer_expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and bus outputs decode from state; RST forces them idle immediately.
  assign bus_act   = !RST && (state_q == StBus);
  assign req_ready = !RST && (state_q == StIdle);
  assign rsp_valid = !RST && (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign A         = bus_act ? addr_q : '0;
  assign W         = bus_act && write_q;
  assign DOE       = bus_act && write_q;
  assign DOUT      = DOE ? wdata_q : '0;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Self-checking bench for cpu_bus_master (default 16-bit widths, TIMEOUT=15).
module tb_cpu_bus_master;

  localparam int unsigned TO = 15;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] A;
  logic [15:0] DOUT;
  logic        DOE;
  logic        W;
  logic [15:0] DIN;
  logic        RDY;

  cpu_bus_master #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .TIMEOUT (TO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .A         (A),
    .DOUT      (DOUT),
    .DOE       (DOE),
    .W         (W),
    .DIN       (DIN),
    .RDY       (RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    int          waits;     // low-RDY BUS cycles before the final one
    logic        rdy_end;   // RDY in the final BUS cycle (0 = let it time out)
    int          hold;      // cycles of rsp_ready=0 before the handshake
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  function automatic vec_t mk(logic wr, logic [15:0] addr, logic [15:0] wdata,
                              logic [15:0] din, int waits, logic rdy_end, int hold,
                              logic [15:0] exp_rdata, logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.din = din; v.waits = waits;
    v.rdy_end = rdy_end; v.hold = hold; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, " A"}, 32'(A), 32'h0);
    check({tag, " W"}, 32'(W), 32'h0);
    check({tag, " DOE"}, 32'(DOE), 32'h0);
    check({tag, " DOUT"}, 32'(DOUT), 32'h0);
  endtask

  // One complete transfer, starting #1 after a rising edge with the DUT in IDLE.
  task automatic run_txn(input vec_t v, input int idx);
    string tag;
    exp_t  e;
    tag = $sformatf("v%0d", idx);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    RDY = 1'b0; rsp_ready = 1'b0;
    #1;
    check({tag, " req_ready idle"}, 32'(req_ready), 32'h1);
    sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(posedge CLK); #1;
    req_valid = 1'b0;
    for (int i = 0; i <= v.waits; i++) begin
      RDY = (i == v.waits) ? v.rdy_end : 1'b0;
      DIN = (i == v.waits) ? v.din : ~v.din;
      #1;
      check($sformatf("%s bus%0d A", tag, i), 32'(A), 32'(v.addr));
      check($sformatf("%s bus%0d W", tag, i), 32'(W), 32'(v.wr));
      check($sformatf("%s bus%0d DOE", tag, i), 32'(DOE), 32'(v.wr));
      check($sformatf("%s bus%0d DOUT", tag, i), 32'(DOUT), v.wr ? 32'(v.wdata) : 32'h0);
      check($sformatf("%s bus%0d req_ready", tag, i), 32'(req_ready), 32'h0);
      check($sformatf("%s bus%0d rsp_valid", tag, i), 32'(rsp_valid), 32'h0);
      @(posedge CLK); #1;
    end
    // Junk on RDY/DIN and a competing request while the response is held.
    RDY = 1'b1; DIN = 16'h0BAD;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hDEAD;
    for (int i = 0; i <= v.hold; i++) begin
      rsp_ready = (i == v.hold);
      #1;
      check($sformatf("%s resp%0d rsp_valid", tag, i), 32'(rsp_valid), 32'h1);
      check($sformatf("%s resp%0d rdata", tag, i), 32'(rsp_rdata), 32'(v.exp_rdata));
      check($sformatf("%s resp%0d req_ready", tag, i), 32'(req_ready), 32'h0);
      check_idle_bus($sformatf("%s resp%0d", tag, i));
      if (i == v.hold) begin
        check({tag, " sb nonempty"}, 32'(sb_q.size() != 0), 32'h1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check({tag, " sb rdata"}, 32'(rsp_rdata), 32'(e.rdata));
          check({tag, " sb err"}, 32'(rsp_err), 32'(e.err));
        end
      end
      @(posedge CLK); #1;
    end
    rsp_ready = 1'b0; req_valid = 1'b0; RDY = 1'b0;
    #1;
    check({tag, " back idle req_ready"}, 32'(req_ready), 32'h1);
    check({tag, " back idle rsp_valid"}, 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; DIN = '0; RDY = 1'b0;

    vecs.push_back(mk(1'b0, 16'h1234, 16'h0000, 16'hBEEF, 0, 1'b1, 0, 16'hBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 16'h0040, 16'hA5A5, 16'h7777, 3, 1'b1, 0, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1, 1'b1, 5, 16'h5A5A, 1'b0));
    vecs.push_back(mk(1'b1, 16'hFFFF, 16'hFFFF, 16'h1357, 0, 1'b1, 2, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b0, 16'h8000, 16'h0000, 16'h0000, 2, 1'b1, 1, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0001, 16'h0000, 16'hFFFF, 5, 1'b1, 0, 16'hFFFF, 1'b0));
`ifdef CPU_BUS_TIMEOUT_EN
    // RDY never comes: error after TO BUS cycles; RDY in the last cycle still wins.
    vecs.push_back(mk(1'b0, 16'h0100, 16'h0000, 16'hCAFE, TO - 1, 1'b0, 2, 16'h0000, 1'b1));
    vecs.push_back(mk(1'b1, 16'h0200, 16'h3C3C, 16'hCAFE, TO - 1, 1'b0, 0, 16'h0000, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0300, 16'h0000, 16'h4242, TO - 1, 1'b1, 0, 16'h4242, 1'b0));
`else
    vecs.push_back(mk(1'b0, 16'h0400, 16'h0000, 16'h0001, 100, 1'b1, 0, 16'h0001, 1'b0));
`endif

    // Reset state.
    @(posedge CLK); #1;
    check("rst req_ready", 32'(req_ready), 32'h0);
    check("rst rsp_valid", 32'(rsp_valid), 32'h0);
    check_idle_bus("rst");
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    check("post-rst req_ready", 32'(req_ready), 32'h1);
    check("post-rst rsp_valid", 32'(rsp_valid), 32'h0);
    check("post-rst rdata", 32'(rsp_rdata), 32'h0);
    check("post-rst err", 32'(rsp_err), 32'h0);
    @(posedge CLK); #1;

    foreach (vecs[k]) run_txn(vecs[k], k);

    // Reset during the wait phase of a write: transfer abandoned, no response.
    @(posedge CLK); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 16'h1111; RDY = 1'b0;
    #1;
    check("mid-rst accept", 32'(req_ready), 32'h1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    #1;
    check("mid-rst bus W", 32'(W), 32'h1);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    check("mid-rst hi req_ready", 32'(req_ready), 32'h0);
    check("mid-rst hi rsp_valid", 32'(rsp_valid), 32'h0);
    check_idle_bus("mid-rst hi");
    @(posedge CLK); #1;
    check("mid-rst edge W", 32'(W), 32'h0);
    check("mid-rst edge DOE", 32'(DOE), 32'h0);
    check("mid-rst edge rsp_valid", 32'(rsp_valid), 32'h0);
    RST = 1'b0; RDY = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("after-rst%0d rsp_valid", i), 32'(rsp_valid), 32'h0);
      check($sformatf("after-rst%0d req_ready", i), 32'(req_ready), 32'h1);
      check($sformatf("after-rst%0d W", i), 32'(W), 32'h0);
      @(posedge CLK); #1;
    end
    RDY = 1'b0; rsp_ready = 1'b0;
    check("sb drained", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Parametrised memory-bus front end for the next-generation microcoded CPU.
- Replaces direct tristate A/D/W driving from the core with a request/response handshake toward the core and a wait-state-aware external bus.
- Data and address widths are generic.
- Split data-in/data-out with output enable; the top level owns the tristate.
- Adds a wait-state (RDY) protocol and an optional bus timeout.

Parameters:
- DATA_W, 16, data bus width in bits.
- ADDR_W, 16, address bus width in bits.
- TIMEOUT, 15, maximum wait cycles before a transfer errors; must be at least 1. Used only with CPU_BUS_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a transfer.
- req_ready  out  1  block can accept a transfer.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  transfer address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  transfer complete; response fields valid.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  transfer timed out.
- A  out  ADDR_W  external address.
- DOUT  out  DATA_W  external write data.
- DOE  out  1  DOUT enable; top level drives D when high.
- W  out  1  external write strobe.
- DIN  in  DATA_W  external read data.
- RDY  in  1  external device completes the current cycle.

Behaviour:
- Reset values:
  - Synchronous RST forces state IDLE and clears addr_q, wdata_q, write_q, rdata_q, err_q and wait_cnt.
  - While RST is high, req_ready, rsp_valid, A, DOUT, DOE and W are all 0.
- FSM states are IDLE, BUS and RESP.
- IDLE:
  - req_ready=1; A=0, W=0, DOE=0.
  - On req_valid&&req_ready, capture addr/wdata/write into registers, clear wait_cnt and go to BUS.
- BUS:
  - A=addr_q, W=write_q, DOE=write_q, DOUT=wdata_q (DOUT is 0 when DOE=0).
  - req_ready=0.
  - If RDY=1: for a read, latch rdata_q=DIN (for a write, rdata_q=0); set err_q=0; go to RESP.
  - Else, with timeout enabled: if wait_cnt==TIMEOUT-1, set err_q=1, rdata_q=0 and go to RESP; otherwise increment wait_cnt.
- RESP:
  - rsp_valid=1; rsp_rdata=rdata_q and rsp_err=err_q are held stable until the handshake.
  - Bus outputs are idle (A=0, W=0, DOE=0).
  - On rsp_ready, go to IDLE.
  - RDY is ignored in RESP.
- Latency:
  - Request accepted at edge t; BUS is active in cycle t+1.
  - If RDY=1 in that cycle, rsp_valid rises at t+2.
  - Each low-RDY cycle adds one cycle of latency.
- Throughput: one transfer per 3 cycles minimum.
- rsp_valid, once high, stays high until rsp_ready; it does not depend on req_valid.
- RDY and the timeout expiring in the same cycle: RDY wins and the transfer succeeds (err=0).
- wait_cnt width is clog2(TIMEOUT+1); it saturates and never wraps.
- Reset asserted in BUS or RESP: the transfer is abandoned, no response is produced, and the bus goes idle on the same edge.

Optional Feature:
- Macro: CPU_BUS_TIMEOUT_EN.
- Defined: timeout logic and wait_cnt are present as described above; rsp_err reports expiry.
- Undefined: BUS waits indefinitely for RDY; wait_cnt is not instantiated; rsp_err is tied to 0.

Decomposition:
- Package cpu_bus_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - default width constants DATA_W_DEF=16, ADDR_W_DEF=16;
  - TIMEOUT_DEF=15.
- One sub-module, cpu_bus_wait_timer, is natural: a saturating counter with clear/enable inputs and an `expired` output at TIMEOUT-1. It is instantiated only under CPU_BUS_TIMEOUT_EN.

Test Plan:
1. Zero-wait read:
   - Stimulus: req at t with addr=0x1234, read; RDY=1; DIN=0xBEEF.
   - Response: A=0x1234, W=0, DOE=0 in cycle t+1; rsp_valid at t+2 with rdata=0xBEEF, err=0.
2. Write with 3 wait states:
   - Stimulus: addr=0x0040, wdata=0xA5A5; RDY low for 3 cycles, then high.
   - Response: W=1, DOE=1, DOUT=0xA5A5 for 4 BUS cycles; rsp_valid at t+5 with rdata=0, err=0.
3. Timeout (macro defined, TIMEOUT=15):
   - Stimulus: RDY held at 0.
   - Response: rsp_err=1 and rsp_valid after 15 BUS cycles; bus idle during RESP.
   - RDY rising on the 15th cycle instead: err=0.
4. Response backpressure:
   - Stimulus: rsp_ready=0 for 5 cycles.
   - Response: rsp_valid and rdata stay stable; req_ready=0 throughout; next req accepted only after IDLE returns.
5. Reset mid-BUS:
   - Stimulus: assert RST during the wait phase of a write.
   - Response: next cycle W=0, DOE=0, rsp_valid=0; no response is ever issued; after reset release, req_ready=1.
6. Macro undefined:
   - Stimulus: RDY low for 100 cycles, then high with DIN=0x0001.
   - Response: rsp_valid with rdata=0x0001, err=0.
